// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Shared RV32I definitions for the execute stage.
//   - XLEN         : integer register width
//   - branch_f3_t  : B-type funct3 encodings for the branch conditions
//   Codes 3'b010 and 3'b011 have no branch meaning and are treated as illegal
//   by consumers of this enum.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_t;

endpackage

// File: rtl/branch_cmp_core.sv
// branch_cmp_core
//   Purely combinational magnitude/equality unit for two XLEN operands.
//   Ports:
//     rs1, rs2 : operands
//     eq       : rs1 == rs2 (bitwise)
//     lt_s     : rs1 <  rs2, two's-complement
//     lt_u     : rs1 <  rs2, unsigned
module branch_cmp_core
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            eq,
    output logic            lt_s,
    output logic            lt_u
);

    // One subtractor on the sign-extended operands serves all three results.
    logic [XLEN:0] diff_s;

    assign diff_s = {rs1[XLEN-1], rs1} - {rs2[XLEN-1], rs2};

    // The low XLEN bits of the difference are identical to the unsigned
    // difference, so a zero result means equal operands.
    assign eq   = (diff_s[XLEN-1:0] == '0);

    // Sign of the widened difference is the signed less-than.
    assign lt_s = diff_s[XLEN];

    // The zero-extended subtraction shares the same carry into the top bit;
    // its top bit differs from the sign-extended one by the two extension
    // bits, so the unsigned borrow is recovered with two XORs.
    assign lt_u = diff_s[XLEN] ^ rs1[XLEN-1] ^ rs2[XLEN-1];

endmodule

// File: rtl/branch_compare.sv
// branch_compare
//   Branch-condition evaluator for the RV32I execute stage.
//   Ports:
//     clk        : core clock (registered outputs only)
//     rst_n      : asynchronous active-low reset of the output flops
//     rs1, rs2   : source operands
//     funct3     : B-type branch condition selector
//     brq        : combinational branch-taken
//     illegal    : combinational, funct3 is not a branch condition
//     brq_r      : brq delayed by one clk edge
//     illegal_r  : illegal delayed by one clk edge
module branch_compare
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            brq,
    output logic            illegal,
    output logic            brq_r,
    output logic            illegal_r
);

    logic eq;
    logic lt_s;
    logic lt_u;
    logic brq_c;
    logic illegal_c;

    branch_cmp_core u_core (
        .rs1  (rs1),
        .rs2  (rs2),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    always_comb begin
        brq_c     = 1'b0;
        illegal_c = 1'b0;
        case (funct3)
            F3_BEQ:  brq_c = eq;
            F3_BNE:  brq_c = ~eq;
            F3_BLT:  brq_c = lt_s;
            F3_BGE:  brq_c = ~lt_s;
            F3_BLTU: brq_c = lt_u;
            F3_BGEU: brq_c = ~lt_u;
            default: illegal_c = 1'b1;
        endcase
    end

    assign brq     = brq_c;
    assign illegal = illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brq_r     <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            brq_r     <= brq_c;
            illegal_r <= illegal_c;
        end
    end

endmodule

// File: tb/tb_branch_compare.sv
// tb_branch_compare
//   Self-checking bench for branch_compare: directed cases for each branch
//   condition and the signed/unsigned extremes, reset behaviour of the
//   registered outputs, and randomized back-to-back traffic against a
//   reference model built from integer arithmetic.
module tb_branch_compare;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic        brq;
    logic        illegal;
    logic        brq_r;
    logic        illegal_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_compare dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .brq       (brq),
        .illegal   (illegal),
        .brq_r     (brq_r),
        .illegal_r (illegal_r)
    );

    // Reference: operands widened to 64-bit integers, signed or unsigned,
    // then compared with ordinary integer relations.
    function automatic logic model_brq(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa <  sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua <  ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_illegal(input logic [2:0] f);
        return (f == 3'd2) || (f == 3'd3);
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        funct3 = 3'b000;
        #2;
        checks++;
        if (brq_r !== 1'b0 || illegal_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: brq_r=%b illegal_r=%b, required 0 0", brq_r, illegal_r);
        end
        checks++;
        if (brq !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb_unaffected: brq=%b, required 1", brq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (brq_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: brq_r=%b, required 0", brq_r);
        end
    endtask

    task automatic test_beq_bne();
        logic [2:0]  f[4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic [31:0] a[4] = '{32'd0, 32'd10, 32'd10, -32'sd10};
        logic [31:0] b[4] = '{-32'sd0, -32'sd10, -32'sd10, -32'sd10};
        logic        e[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            funct3 = f[i];
            rs1    = a[i];
            rs2    = b[i];
            #1;
            checks++;
            if (brq !== e[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL beq_bne[%0d]: brq=%b illegal=%b, required %b 0", i, brq, illegal, e[i]);
            end
        end
    endtask

    task automatic test_blt_bge();
        logic [2:0]  f[5] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b101};
        logic [31:0] a[5] = '{-32'sd10, 32'd10, 32'd10, 32'd10, -32'sd10};
        logic [31:0] b[5] = '{32'd10, -32'sd10, -32'sd10, 32'd10, 32'd10};
        logic        e[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            funct3 = f[i];
            rs1    = a[i];
            rs2    = b[i];
            #1;
            checks++;
            if (brq !== e[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL blt_bge[%0d]: brq=%b illegal=%b, required %b 0", i, brq, illegal, e[i]);
            end
        end
    endtask

    task automatic test_bltu_bgeu();
        logic [2:0]  f[5] = '{3'b110, 3'b110, 3'b111, 3'b111, 3'b111};
        logic [31:0] a[5] = '{32'd10, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] b[5] = '{32'd11, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1};
        logic        e[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            funct3 = f[i];
            rs1    = a[i];
            rs2    = b[i];
            #1;
            checks++;
            if (brq !== e[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL bltu_bgeu[%0d]: brq=%b illegal=%b, required %b 0", i, brq, illegal, e[i]);
            end
        end
    endtask

    task automatic test_illegal_extremes();
        logic [2:0]  f[6] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a[6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[6] = '{32'd5, 32'd7, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic        e[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        il[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            funct3 = f[i];
            rs1    = a[i];
            rs2    = b[i];
            #1;
            checks++;
            if (brq !== e[i] || illegal !== il[i]) begin
                errors++;
                $display("FAIL illegal_extremes[%0d]: brq=%b illegal=%b, required %b %b", i, brq, illegal, e[i], il[i]);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst_n  = 1'b1;
        funct3 = 3'b000;
        rs1    = 32'd5;
        rs2    = 32'd5;
        #1;
        checks++;
        if (brq_r !== 1'b0) begin
            errors++;
            $display("FAIL reg_before_edge: brq_r=%b, required 0", brq_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (brq_r !== 1'b1 || illegal_r !== 1'b0) begin
            errors++;
            $display("FAIL reg_beq_one_edge: brq_r=%b illegal_r=%b, required 1 0", brq_r, illegal_r);
        end
        // mid-cycle asynchronous reset clears brq_r without waiting for an edge
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (brq_r !== 1'b0) begin
            errors++;
            $display("FAIL reg_async_reset_brq: brq_r=%b, required 0", brq_r);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        funct3 = 3'b011;
        @(posedge clk);
        #1;
        checks++;
        if (illegal_r !== 1'b1 || brq_r !== 1'b0) begin
            errors++;
            $display("FAIL reg_illegal: illegal_r=%b brq_r=%b, required 1 0", illegal_r, brq_r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (illegal_r !== 1'b0) begin
            errors++;
            $display("FAIL reg_async_reset_illegal: illegal_r=%b, required 0", illegal_r);
        end
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb_illegal: illegal=%b, required 1", illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners[6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_back_to_back();
        logic exp_brq_q[$];
        logic exp_ill_q[$];
        logic exp_b;
        logic exp_i;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            funct3 = 3'($urandom_range(0, 7));
            rs1    = pick_operand();
            rs2    = ($urandom_range(0, 4) == 0) ? rs1 : pick_operand();
            #1;
            checks++;
            if (brq !== model_brq(funct3, rs1, rs2) || illegal !== model_illegal(funct3)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: f3=%b rs1=%h rs2=%h brq=%b illegal=%b, required %b %b",
                         i, funct3, rs1, rs2, brq, illegal,
                         model_brq(funct3, rs1, rs2), model_illegal(funct3));
            end
            exp_brq_q.push_back(model_brq(funct3, rs1, rs2));
            exp_ill_q.push_back(model_illegal(funct3));
            @(posedge clk);
            #1;
            exp_b = exp_brq_q.pop_front();
            exp_i = exp_ill_q.pop_front();
            checks++;
            if (brq_r !== exp_b || illegal_r !== exp_i) begin
                errors++;
                $display("FAIL rand_reg[%0d]: brq_r=%b illegal_r=%b, required %b %b", i, brq_r, illegal_r, exp_b, exp_i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beq_bne();
        test_blt_bge();
        test_bltu_bgeu();
        test_illegal_extremes();
        test_registered();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
